// File: rtl/gci_std_display_prog_timing.sv
// -----------------------------------------------------------------------------
// gci_std_display_prog_timing
//
// Runtime-programmable display timing generator (pixel clock domain).
// Generates sync, data-enable/blank, an early pixel-fetch request, active-area
// pixel coordinates and line/frame strobes. New timing is written into a
// shadow register and only becomes active on a frame boundary (or an explicit
// iRESET_SYNC), so a mode change never tears a frame.
//
// Ports
//   iDISP_CLOCK            pixel clock
//   inRESET                asynchronous active-low reset (restores defaults)
//   iRESET_SYNC            synchronous counter restart; also applies a pending
//                          shadow config and drives onDISP_RESET low
//   iCFG_VALID             one-cycle config write strobe
//   iCFG_HP/HB/HA/HF       horizontal sync/back/active/front widths (clocks)
//   iCFG_VP/VB/VA/VF       vertical sync/back/active/front heights (lines)
//   iCFG_HPOL/VPOL         sync polarity, 1 = active-high
//   oCFG_PENDING           shadow config waiting for the frame boundary
//   oCFG_ERR               one-cycle pulse for a rejected write
//   oDATA_REQ              pixel fetch request, leads oDISP_ENA by P_REQ_LEAD
//   oDATA_SYNC             last cycle of frame
//   oLINE_END              last cycle of line
//   oDISP_ENA/oDISP_BLANK  active video and its inverse
//   oDISP_HSYNC/VSYNC      sync outputs with polarity applied
//   oPIX_X/oPIX_Y          active-area column/row (0 outside active video)
//   onDISP_RESET           panel reset, active-low
// All outputs are registered: the value after edge n+1 decodes the counters
// as they stood during cycle n.
// -----------------------------------------------------------------------------
module gci_std_display_prog_timing #(
  parameter int P_H_WIDTH  = 12,
  parameter int P_V_WIDTH  = 11,
  parameter int P_REQ_LEAD = 2,
  parameter int P_DEF_HP   = 95,
  parameter int P_DEF_HB   = 48,
  parameter int P_DEF_HA   = 640,
  parameter int P_DEF_HF   = 15,
  parameter int P_DEF_VP   = 2,
  parameter int P_DEF_VB   = 33,
  parameter int P_DEF_VA   = 480,
  parameter int P_DEF_VF   = 10,
  parameter bit P_DEF_HPOL = 1'b0,
  parameter bit P_DEF_VPOL = 1'b0
) (
  input  logic                 iDISP_CLOCK,
  input  logic                 inRESET,
  input  logic                 iRESET_SYNC,
  input  logic                 iCFG_VALID,
  input  logic [P_H_WIDTH-1:0] iCFG_HP,
  input  logic [P_H_WIDTH-1:0] iCFG_HB,
  input  logic [P_H_WIDTH-1:0] iCFG_HA,
  input  logic [P_H_WIDTH-1:0] iCFG_HF,
  input  logic [P_V_WIDTH-1:0] iCFG_VP,
  input  logic [P_V_WIDTH-1:0] iCFG_VB,
  input  logic [P_V_WIDTH-1:0] iCFG_VA,
  input  logic [P_V_WIDTH-1:0] iCFG_VF,
  input  logic                 iCFG_HPOL,
  input  logic                 iCFG_VPOL,
  output logic                 oCFG_PENDING,
  output logic                 oCFG_ERR,
  output logic                 oDATA_REQ,
  output logic                 oDATA_SYNC,
  output logic                 oLINE_END,
  output logic                 oDISP_ENA,
  output logic                 oDISP_BLANK,
  output logic                 oDISP_HSYNC,
  output logic                 oDISP_VSYNC,
  output logic [P_H_WIDTH-1:0] oPIX_X,
  output logic [P_V_WIDTH-1:0] oPIX_Y,
  output logic                 onDISP_RESET
);

  localparam int HW = P_H_WIDTH;
  localparam int VW = P_V_WIDTH;

  typedef struct packed {
    logic [HW-1:0] hp, hb, ha, hf;
    logic [VW-1:0] vp, vb, va, vf;
    logic          hpol, vpol;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    hp: HW'(P_DEF_HP), hb: HW'(P_DEF_HB), ha: HW'(P_DEF_HA), hf: HW'(P_DEF_HF),
    vp: VW'(P_DEF_VP), vb: VW'(P_DEF_VB), va: VW'(P_DEF_VA), vf: VW'(P_DEF_VF),
    hpol: P_DEF_HPOL, vpol: P_DEF_VPOL
  };

  // Totals are limited to 2^W so the counters (W bits) can reach HT-1/VT-1.
  localparam logic [HW+1:0] H_LIMIT = (HW+2)'(1) << HW;
  localparam logic [VW+1:0] V_LIMIT = (VW+2)'(1) << VW;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  cfg_t          act_q, act_d;
  cfg_t          shd_q, shd_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          req_q, req_d;
  logic          sync_q, sync_d;
  logic          le_q, le_d;
  logic          ena_q, ena_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [HW-1:0] px_q, px_d;
  logic [VW-1:0] py_q, py_d;
  logic          nrst_q, nrst_d;

  // ---------------------------------------------------------------------------
  // Write validation (sums two bits wider so four max-size fields cannot wrap)
  // ---------------------------------------------------------------------------
  cfg_t          wr_cfg;
  logic [HW+1:0] wr_ht;
  logic [VW+1:0] wr_vt;
  logic          wr_ok;

  assign wr_cfg = '{hp: iCFG_HP, hb: iCFG_HB, ha: iCFG_HA, hf: iCFG_HF,
                    vp: iCFG_VP, vb: iCFG_VB, va: iCFG_VA, vf: iCFG_VF,
                    hpol: iCFG_HPOL, vpol: iCFG_VPOL};

  assign wr_ht = (HW+2)'(iCFG_HP) + (HW+2)'(iCFG_HB) + (HW+2)'(iCFG_HA) + (HW+2)'(iCFG_HF);
  assign wr_vt = (VW+2)'(iCFG_VP) + (VW+2)'(iCFG_VB) + (VW+2)'(iCFG_VA) + (VW+2)'(iCFG_VF);

  // A back porch shorter than the request lead would start REQ inside the
  // sync pulse of the same line, so it is rejected with the other bad values.
  assign wr_ok = (iCFG_HP != '0) && (iCFG_HB != '0) && (iCFG_HA != '0) && (iCFG_HF != '0) &&
                 (iCFG_VP != '0) && (iCFG_VB != '0) && (iCFG_VA != '0) && (iCFG_VF != '0) &&
                 (iCFG_HB >= HW'(P_REQ_LEAD)) &&
                 (wr_ht <= H_LIMIT) && (wr_vt <= V_LIMIT);

  // ---------------------------------------------------------------------------
  // Active-config window bounds (one bit wider than the fields)
  // ---------------------------------------------------------------------------
  logic [HW:0] ht, h_ext, h_act_lo, h_act_hi, h_req_lo, h_req_hi;
  logic [VW:0] vt, v_ext, v_act_lo, v_act_hi;
  logic        line_end, frame_end, v_win, apply_now;

  assign ht       = {1'b0, act_q.hp} + {1'b0, act_q.hb} + {1'b0, act_q.ha} + {1'b0, act_q.hf};
  assign vt       = {1'b0, act_q.vp} + {1'b0, act_q.vb} + {1'b0, act_q.va} + {1'b0, act_q.vf};
  assign h_ext    = {1'b0, h_q};
  assign v_ext    = {1'b0, v_q};
  assign h_act_lo = {1'b0, act_q.hp} + {1'b0, act_q.hb};
  assign h_act_hi = h_act_lo + {1'b0, act_q.ha};
  assign h_req_lo = h_act_lo - (HW+1)'(P_REQ_LEAD);
  assign h_req_hi = h_act_hi - (HW+1)'(P_REQ_LEAD);
  assign v_act_lo = {1'b0, act_q.vp} + {1'b0, act_q.vb};
  assign v_act_hi = v_act_lo + {1'b0, act_q.va};

  assign line_end  = (h_ext == ht - (HW+1)'(1));
  assign frame_end = line_end && (v_ext == vt - (VW+1)'(1));
  assign v_win     = (v_ext >= v_act_lo) && (v_ext < v_act_hi);
  assign apply_now = frame_end || iRESET_SYNC;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    h_d    = h_q + HW'(1);
    v_d    = v_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;

    // Counters restart on a frame boundary or a sync restart; the new
    // config (if any) governs the cycle right after.
    if (apply_now) begin
      h_d = '0;
      v_d = '0;
    end else if (line_end) begin
      h_d = '0;
      v_d = v_q + VW'(1);
    end

    // A valid write that lands on the apply edge goes straight to the
    // active set; otherwise a pending shadow is applied, otherwise the
    // write parks in the shadow (last write wins).
    if (iCFG_VALID && wr_ok && apply_now) begin
      act_d  = wr_cfg;
      shd_d  = wr_cfg;
      pend_d = 1'b0;
    end else if (apply_now && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end else if (iCFG_VALID && wr_ok) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end

    err_d  = iCFG_VALID && !wr_ok;
    nrst_d = !iRESET_SYNC;

    // Output decode of the current counters under the current active config.
    ena_d  = v_win && (h_ext >= h_act_lo) && (h_ext < h_act_hi);
    req_d  = v_win && (h_ext >= h_req_lo) && (h_ext < h_req_hi);
    le_d   = line_end;
    sync_d = frame_end;
    hs_d   = (h_q < act_q.hp) ^ ~act_q.hpol;
    vs_d   = (v_q < act_q.vp) ^ ~act_q.vpol;
    px_d   = ena_d ? HW'(h_ext - h_act_lo) : '0;
    py_d   = ena_d ? VW'(v_ext - v_act_lo) : '0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      h_q    <= '0;
      v_q    <= '0;
      act_q  <= DEF_CFG;
      shd_q  <= DEF_CFG;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      req_q  <= 1'b0;
      sync_q <= 1'b0;
      le_q   <= 1'b0;
      ena_q  <= 1'b0;
      hs_q   <= ~P_DEF_HPOL;
      vs_q   <= ~P_DEF_VPOL;
      px_q   <= '0;
      py_q   <= '0;
      nrst_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      h_q    <= h_d;
      v_q    <= v_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      req_q  <= req_d;
      sync_q <= sync_d;
      le_q   <= le_d;
      ena_q  <= ena_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      px_q   <= px_d;
      py_q   <= py_d;
      nrst_q <= nrst_d;
    end
  end

  assign oCFG_PENDING = pend_q;
  assign oCFG_ERR     = err_q;
  assign oDATA_REQ    = req_q;
  assign oDATA_SYNC   = sync_q;
  assign oLINE_END    = le_q;
  assign oDISP_ENA    = ena_q;
  assign oDISP_BLANK  = ~ena_q;
  assign oDISP_HSYNC  = hs_q;
  assign oDISP_VSYNC  = vs_q;
  assign oPIX_X       = px_q;
  assign oPIX_Y       = py_q;
  assign onDISP_RESET = nrst_q;

endmodule

// File: tb/tb_gci_std_display_prog_timing.sv
// -----------------------------------------------------------------------------
// tb_gci_std_display_prog_timing
//
// Directed bench. A cycle model computes the expected registered outputs for
// each clock as stimulus is driven; they are queued and compared against the
// DUT on the following falling edge. Directed checks with hand-derived
// constants cover the small test mode, config pending/apply, rejected writes,
// polarity and asynchronous reset back to 640x480.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gci_std_display_prog_timing;

  localparam int HW   = 12;
  localparam int VW   = 11;
  localparam int LEAD = 2;

  typedef struct packed {
    int hp, hb, ha, hf, vp, vb, va, vf;
    bit hpol, vpol;
  } tcfg_t;

  // {pend, err, req, sync, le, ena, blank, hs, vs, nrst, pix_x[12], pix_y[11]}
  localparam logic [32:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 11'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n, rst_sync, cfg_valid;
  tcfg_t wr;

  logic          oCFG_PENDING, oCFG_ERR, oDATA_REQ, oDATA_SYNC, oLINE_END;
  logic          oDISP_ENA, oDISP_BLANK, oDISP_HSYNC, oDISP_VSYNC, onDISP_RESET;
  logic [HW-1:0] oPIX_X;
  logic [VW-1:0] oPIX_Y;

  gci_std_display_prog_timing dut (
    .iDISP_CLOCK (clk),
    .inRESET     (rst_n),
    .iRESET_SYNC (rst_sync),
    .iCFG_VALID  (cfg_valid),
    .iCFG_HP     (HW'(wr.hp)),
    .iCFG_HB     (HW'(wr.hb)),
    .iCFG_HA     (HW'(wr.ha)),
    .iCFG_HF     (HW'(wr.hf)),
    .iCFG_VP     (VW'(wr.vp)),
    .iCFG_VB     (VW'(wr.vb)),
    .iCFG_VA     (VW'(wr.va)),
    .iCFG_VF     (VW'(wr.vf)),
    .iCFG_HPOL   (wr.hpol),
    .iCFG_VPOL   (wr.vpol),
    .oCFG_PENDING(oCFG_PENDING),
    .oCFG_ERR    (oCFG_ERR),
    .oDATA_REQ   (oDATA_REQ),
    .oDATA_SYNC  (oDATA_SYNC),
    .oLINE_END   (oLINE_END),
    .oDISP_ENA   (oDISP_ENA),
    .oDISP_BLANK (oDISP_BLANK),
    .oDISP_HSYNC (oDISP_HSYNC),
    .oDISP_VSYNC (oDISP_VSYNC),
    .oPIX_X      (oPIX_X),
    .oPIX_Y      (oPIX_Y),
    .onDISP_RESET(onDISP_RESET)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int nstep   = 0;

  // Model state
  int            mh, mv;
  bit            m_pend;
  tcfg_t         m_act, m_sh;
  logic [32:0]   exp_q[$];

  function automatic tcfg_t mk(int hp, int hb, int ha, int hf,
                               int vp, int vb, int va, int vf, bit hpol, bit vpol);
    tcfg_t c;
    c.hp = hp; c.hb = hb; c.ha = ha; c.hf = hf;
    c.vp = vp; c.vb = vb; c.va = va; c.vf = vf;
    c.hpol = hpol; c.vpol = vpol;
    return c;
  endfunction

  function automatic int tot_h(tcfg_t c); return c.hp + c.hb + c.ha + c.hf; endfunction
  function automatic int tot_v(tcfg_t c); return c.vp + c.vb + c.va + c.vf; endfunction

  function automatic bit cfg_ok(tcfg_t c);
    return c.hp > 0 && c.hb > 0 && c.ha > 0 && c.hf > 0 &&
           c.vp > 0 && c.vb > 0 && c.va > 0 && c.vf > 0 &&
           c.hb >= LEAD && tot_h(c) <= (1 << HW) && tot_v(c) <= (1 << VW);
  endfunction

  function automatic logic [32:0] dut_vec();
    return {oCFG_PENDING, oCFG_ERR, oDATA_REQ, oDATA_SYNC, oLINE_END, oDISP_ENA,
            oDISP_BLANK, oDISP_HSYNC, oDISP_VSYNC, onDISP_RESET, oPIX_X, oPIX_Y};
  endfunction

  // Expected decode of the model counters (pend/err/nrst slots left 0).
  function automatic logic [32:0] decode();
    int hlo, hhi, vlo, vhi, ht, vt;
    bit vwin, ena, req, le, sy, hs, vs;
    hlo  = m_act.hp + m_act.hb;
    hhi  = hlo + m_act.ha;
    vlo  = m_act.vp + m_act.vb;
    vhi  = vlo + m_act.va;
    ht   = tot_h(m_act);
    vt   = tot_v(m_act);
    vwin = (mv >= vlo) && (mv < vhi);
    ena  = vwin && (mh >= hlo) && (mh < hhi);
    req  = vwin && (mh + LEAD >= hlo) && (mh + LEAD < hhi);
    le   = (mh == ht - 1);
    sy   = le && (mv == vt - 1);
    hs   = (mh < m_act.hp) ? m_act.hpol : !m_act.hpol;
    vs   = (mv < m_act.vp) ? m_act.vpol : !m_act.vpol;
    return {1'b0, 1'b0, req, sy, le, ena, !ena, hs, vs, 1'b0,
            12'(ena ? mh - hlo : 0), 11'(ena ? mv - vlo : 0)};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; m_pend = 1'b0;
    m_act = mk(95, 48, 640, 15, 2, 33, 480, 10, 1'b0, 1'b0);
    m_sh  = m_act;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: model predicts, DUT clocks, prediction is compared.
  task automatic step();
    logic [32:0] e, got, want;
    tcfg_t in_c;
    int    ht, vt;
    bit    wok, fe, app;
    e    = decode();
    ht   = tot_h(m_act);
    vt   = tot_v(m_act);
    in_c = wr;
    wok  = cfg_valid && cfg_ok(in_c);
    fe   = (mh == ht - 1) && (mv == vt - 1);
    app  = fe || rst_sync;
    if (app) begin
      mh = 0; mv = 0;
    end else if (mh == ht - 1) begin
      mh = 0; mv = mv + 1;
    end else begin
      mh = mh + 1;
    end
    if (wok && app) begin
      m_act = in_c; m_sh = in_c; m_pend = 1'b0;
    end else if (app && m_pend) begin
      m_act = m_sh; m_pend = 1'b0;
    end else if (wok) begin
      m_sh = in_c; m_pend = 1'b1;
    end
    e[32] = m_pend;
    e[31] = cfg_valid && !wok;
    e[23] = !rst_sync;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got  = dut_vec();
    want = exp_q.pop_front();
    nstep++;
    check($sformatf("cycle%0d", nstep), 64'(got), 64'(want));
  endtask

  task automatic write_cfg(input tcfg_t c);
    wr = c;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    tcfg_t cfg_a, cfg_b;
    int bad_hs, bad_vs, bad_ena, bad_pix, bad_req, bad_le, bad_sy;
    int n_hs, n_vs, n_ena, req_rise, req_fall, ena_rise, ena_fall;
    int col, line, prev_le, sync_at, first_le, first_ena, px0, py0;
    bit prev_req, prev_ena, exp_ena, exp_req;

    cfg_a = mk(2, 3, 4, 1, 1, 1, 2, 1, 1'b0, 1'b0);
    cfg_b = mk(1, 2, 3, 2, 1, 1, 1, 1, 1'b0, 1'b0);
    rst_n = 1'b0; rst_sync = 1'b0; cfg_valid = 1'b0; wr = cfg_a;
    model_reset();

    // ---- Reset state and release ----
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(dut_vec()), 64'(RST_VEC));
    rst_n = 1'b1;
    step();
    check("nrst_after_release", 64'(onDISP_RESET), 64'(1));
    repeat (5) step();

    // ---- Load small mode, apply with iRESET_SYNC ----
    write_cfg(cfg_a);
    check("pend_after_write", 64'(oCFG_PENDING), 64'(1));
    repeat (2) step();
    check("pend_held", 64'(oCFG_PENDING), 64'(1));
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    check("nrst_low_on_sync", 64'(onDISP_RESET), 64'(0));
    check("pend_cleared_on_sync", 64'(oCFG_PENDING), 64'(0));

    // ---- One 50-clock frame of the small mode ----
    bad_hs = 0; bad_vs = 0; bad_ena = 0; bad_pix = 0; bad_req = 0; bad_le = 0; bad_sy = 0;
    n_hs = 0; n_ena = 0; req_rise = -1; req_fall = -1; ena_rise = -1; ena_fall = -1;
    prev_req = 1'b0; prev_ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 0) check("nrst_high_after_sync", 64'(onDISP_RESET), 64'(1));
      col = i % 10; line = i / 10;
      exp_ena = (col >= 5) && (col <= 8) && (line >= 2) && (line <= 3);
      exp_req = (col >= 3) && (col <= 6) && (line >= 2) && (line <= 3);
      if (oDISP_HSYNC !== !(col < 2)) bad_hs++;
      if (oDISP_VSYNC !== !(line < 1)) bad_vs++;
      if (oDISP_ENA !== exp_ena) bad_ena++;
      if (exp_ena && (oPIX_X !== 12'(col - 5) || oPIX_Y !== 11'(line - 2))) bad_pix++;
      if (oDATA_REQ !== exp_req) bad_req++;
      if (oLINE_END !== (col == 9)) bad_le++;
      if (oDATA_SYNC !== (i == 49)) bad_sy++;
      if (!oDISP_HSYNC) n_hs++;
      if (oDISP_ENA) n_ena++;
      if (oDATA_REQ && !prev_req && req_rise < 0) req_rise = i;
      if (!oDATA_REQ && prev_req && req_fall < 0) req_fall = i;
      if (oDISP_ENA && !prev_ena && ena_rise < 0) ena_rise = i;
      if (!oDISP_ENA && prev_ena && ena_fall < 0) ena_fall = i;
      prev_req = oDATA_REQ;
      prev_ena = oDISP_ENA;
    end
    check("hsync_shape", 64'(bad_hs), 64'(0));
    check("vsync_shape", 64'(bad_vs), 64'(0));
    check("ena_window", 64'(bad_ena), 64'(0));
    check("pix_xy", 64'(bad_pix), 64'(0));
    check("req_window", 64'(bad_req), 64'(0));
    check("line_end_period", 64'(bad_le), 64'(0));
    check("frame_sync_50", 64'(bad_sy), 64'(0));
    check("hsync_low_count", 64'(n_hs), 64'(10));
    check("ena_count", 64'(n_ena), 64'(8));
    check("req_rise_lead", 64'(ena_rise - req_rise), 64'(2));
    check("req_fall_lead", 64'(ena_fall - req_fall), 64'(2));
    check("req_length", 64'(req_fall - req_rise), 64'(4));

    // ---- Mid-frame write: old timing to frame end, then HT = 8 ----
    repeat (13) step();
    write_cfg(cfg_b);
    check("pend_mid_frame", 64'(oCFG_PENDING), 64'(1));
    prev_le = -100; sync_at = -1;
    for (int i = 0; i < 60 && sync_at < 0; i++) begin
      step();
      if (oDATA_SYNC) begin
        sync_at = i;
        check("pend_clear_frame_end", 64'(oCFG_PENDING), 64'(0));
        check("old_line_period", 64'(i - prev_le), 64'(10));
      end else if (oLINE_END) begin
        prev_le = i;
      end
    end
    check("sync_seen", 64'(sync_at >= 0), 64'(1));
    first_le = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (oLINE_END && first_le < 0) first_le = i;
    end
    check("new_line_period", 64'(first_le), 64'(8));

    // ---- Rejected writes ----
    write_cfg(mk(1, 2, 0, 2, 1, 1, 1, 1, 1'b0, 1'b0));
    check("err_ha0", 64'(oCFG_ERR), 64'(1));
    check("pend_ha0", 64'(oCFG_PENDING), 64'(0));
    step();
    check("err_ha0_once", 64'(oCFG_ERR), 64'(0));
    write_cfg(mk(1, 1, 3, 2, 1, 1, 1, 1, 1'b0, 1'b0));
    check("err_hb_lead", 64'(oCFG_ERR), 64'(1));
    check("pend_hb_lead", 64'(oCFG_PENDING), 64'(0));
    step();
    check("err_hb_once", 64'(oCFG_ERR), 64'(0));

    // ---- Write coincident with the frame-end cycle ----
    for (int i = 0; i < 40; i++) begin
      if (mh == tot_h(m_act) - 1 && mv == tot_v(m_act) - 1) break;
      step();
    end
    write_cfg(cfg_a);
    check("coincident_sync", 64'(oDATA_SYNC), 64'(1));
    check("coincident_no_pend", 64'(oCFG_PENDING), 64'(0));
    first_le = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (oLINE_END && first_le < 0) first_le = i;
    end
    check("coincident_new_ht", 64'(first_le), 64'(10));

    // ---- Active-high syncs ----
    write_cfg(mk(2, 3, 4, 1, 1, 1, 2, 1, 1'b1, 1'b1));
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    bad_hs = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (oDISP_HSYNC !== ((i % 10) < 2)) bad_hs++;
      if (oDISP_HSYNC) n_hs++;
      if (oDISP_VSYNC) n_vs++;
    end
    check("hpol_shape", 64'(bad_hs), 64'(0));
    check("hpol_high_count", 64'(n_hs), 64'(10));
    check("vpol_high_count", 64'(n_vs), 64'(10));

    // ---- Async reset mid-line with a pending shadow ----
    write_cfg(cfg_b);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 64'(dut_vec()), 64'(RST_VEC));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    first_le = -1; first_ena = -1; px0 = -1; py0 = -1;
    for (int i = 1; i <= 28100 && first_ena < 0; i++) begin
      step();
      if (oLINE_END && first_le < 0) first_le = i;
      if (oDISP_ENA && first_ena < 0) begin
        first_ena = i;
        px0 = int'(oPIX_X);
        py0 = int'(oPIX_Y);
      end
    end
    check("default_ht_798", 64'(first_le), 64'(798));
    check("default_first_ena", 64'(first_ena), 64'(28074));
    check("default_pix_x0", 64'(px0), 64'(0));
    check("default_pix_y0", 64'(py0), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
